// File: rtl/step_sequencer.sv
// Timed step sequencer: walks NUM_STEPS phases, each holding its own output
// pattern for a programmable tick count, with stop/hold/loop control.
module step_sequencer #(
    parameter int unsigned NUM_STEPS = 3,
    parameter int unsigned OUT_W     = 3,
    parameter int unsigned TIME_W    = 16,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned STEP_W   = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          hold,
    input  logic                          loop_en,
    input  logic [NUM_STEPS*TIME_W-1:0]   step_time,
    input  logic [NUM_STEPS*OUT_W-1:0]    step_out,
    output logic [OUT_W-1:0]              out,
    output logic [STEP_W-1:0]             step,
    output logic                          busy,
    output logic                          step_adv,
    output logic                          done,
    output logic [CNT_W-1:0]              cycle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    logic [STEP_W-1:0]   r_step;
    logic [TIME_W-1:0]   r_elapsed;
    logic [OUT_W-1:0]    r_out;
    logic                r_busy;
    logic                r_step_adv;
    logic                r_done;
    logic [CNT_W-1:0]    r_cycle_cnt;

    logic [TIME_W-1:0]   w_time [NUM_STEPS];
    logic [OUT_W-1:0]    w_pat  [NUM_STEPS];
    logic [STEP_W-1:0]   w_next_step;
    logic                w_last;
    logic [TIME_W:0]     w_elapsed_inc;
    logic                w_complete;

    // Unpack the flat per-step duration and pattern buses (sampled live).
    always_comb begin
        for (int i = 0; i < NUM_STEPS; i++) begin
            w_time[i] = step_time[i*TIME_W +: TIME_W];
            w_pat[i]  = step_out[i*OUT_W +: OUT_W];
        end
    end

    // A zero-length step completes on the next clock without needing a tick.
    assign w_next_step   = r_step + STEP_W'(1);
    assign w_last        = (r_step == STEP_W'(NUM_STEPS - 1));
    assign w_elapsed_inc = {1'b0, r_elapsed} + (TIME_W+1)'(1);
    assign w_complete    = (w_time[r_step] == '0) ||
                           (tick && (w_elapsed_inc >= {1'b0, w_time[r_step]}));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_elapsed   <= '0;
            r_out       <= '0;
            r_busy      <= 1'b0;
            r_step_adv  <= 1'b0;
            r_done      <= 1'b0;
            r_cycle_cnt <= '0;
        end else begin
            r_step_adv <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop && !hold) begin
                        r_state   <= S_RUN;
                        r_step    <= '0;
                        r_elapsed <= '0;
                        r_out     <= w_pat[0];
                        r_busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state   <= S_IDLE;
                        r_step    <= '0;
                        r_elapsed <= '0;
                        r_out     <= '0;
                        r_busy    <= 1'b0;
                    end else if (hold) begin
                        r_state <= S_HOLD;
                        r_out   <= '0;
                    end else if (w_complete) begin
                        r_step_adv <= 1'b1;
                        r_elapsed  <= '0;
                        if (!w_last) begin
                            r_step <= w_next_step;
                            r_out  <= w_pat[w_next_step];
                        end else begin
                            r_done      <= 1'b1;
                            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                            r_step      <= '0;
                            if (loop_en) begin
                                r_out <= w_pat[0];
                            end else begin
                                r_state <= S_IDLE;
                                r_out   <= '0;
                                r_busy  <= 1'b0;
                            end
                        end
                    end else if (tick) begin
                        r_elapsed <= r_elapsed + TIME_W'(1);
                    end
                end
                S_HOLD: begin
                    // Ticks are ignored while frozen, including on the release edge.
                    if (stop) begin
                        r_state   <= S_IDLE;
                        r_step    <= '0;
                        r_elapsed <= '0;
                        r_out     <= '0;
                        r_busy    <= 1'b0;
                    end else if (!hold) begin
                        r_state <= S_RUN;
                        r_out   <= w_pat[r_step];
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_out   <= '0;
                end
            endcase
        end
    end

    assign out       = r_out;
    assign step      = r_step;
    assign busy      = r_busy;
    assign step_adv  = r_step_adv;
    assign done      = r_done;
    assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios plus randomized stimulus, all
// checked every cycle against a tick-counting behavioural model.
module tb_step_sequencer;

    localparam int NS = 3;
    localparam int OW = 3;
    localparam int TW = 16;
    localparam int CW = 16;
    localparam int SW = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               tick = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               hold = 1'b0;
    logic               loop_en = 1'b0;
    logic [NS*TW-1:0]   step_time;
    logic [NS*OW-1:0]   step_out;
    logic [OW-1:0]      out;
    logic [SW-1:0]      step;
    logic               busy;
    logic               step_adv;
    logic               done;
    logic [CW-1:0]      cycle_cnt;

    step_sequencer #(
        .NUM_STEPS(NS), .OUT_W(OW), .TIME_W(TW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .hold(hold), .loop_en(loop_en), .step_time(step_time),
        .step_out(step_out), .out(out), .step(step), .busy(busy),
        .step_adv(step_adv), .done(done), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: running/frozen flags, step index, ticks counted in this step.
    bit m_busy, m_held;
    int m_idx, m_cnt, m_out, m_adv, m_done, m_cyc;

    int tick_pat[8];
    int n_done, n_adv, n_idle, n_tick;
    bit tick_auto = 1'b0;
    int div = 0;

    function automatic int dur(int i);
        return int'(step_time[i*TW +: TW]);
    endfunction

    function automatic int pat(int i);
        return int'(step_out[i*OW +: OW]);
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_zero();
        m_busy = 1'b0; m_held = 1'b0; m_idx = 0; m_cnt = 0;
        m_out = 0; m_adv = 0; m_done = 0; m_cyc = 0;
    endfunction

    function automatic void model_edge();
        int d;
        bit fin;
        m_adv  = 0;
        m_done = 0;
        if (!m_busy) begin
            if (start && !stop && !hold) begin
                m_busy = 1'b1; m_idx = 0; m_cnt = 0; m_out = pat(0);
            end
        end else if (stop) begin
            m_busy = 1'b0; m_held = 1'b0; m_idx = 0; m_cnt = 0; m_out = 0;
        end else if (hold) begin
            m_held = 1'b1; m_out = 0;
        end else if (m_held) begin
            m_held = 1'b0; m_out = pat(m_idx);
        end else begin
            d   = dur(m_idx);
            fin = (d == 0) || (tick && (m_cnt + 1 >= d));
            if (fin) begin
                m_adv = 1; m_cnt = 0; m_idx++;
                if (m_idx == NS) begin
                    m_done = 1;
                    m_cyc  = (m_cyc + 1) % (1 << CW);
                    m_idx  = 0;
                    if (loop_en) m_out = pat(0);
                    else begin m_busy = 1'b0; m_out = 0; end
                end else begin
                    m_out = pat(m_idx);
                end
            end else if (tick) begin
                m_cnt++;
            end
        end
    endfunction

    // One clock: compare against the model at negedge, then advance the model.
    task automatic cyc();
        @(negedge clk);
        check("out",       int'(out),       m_out);
        check("step",      int'(step),      m_idx);
        check("busy",      int'(busy),      int'(m_busy));
        check("step_adv",  int'(step_adv),  m_adv);
        check("done",      int'(done),      m_done);
        check("cycle_cnt", int'(cycle_cnt), m_cyc);
        if (tick) begin
            tick_pat[int'(out)]++;
            n_tick++;
        end
        if (done)     n_done++;
        if (step_adv) n_adv++;
        if (!busy)    n_idle++;
        @(posedge clk);
        if (!rst) model_zero();
        else      model_edge();
        #1;
        if (tick_auto) begin
            div  = (div + 1) % 4;
            tick = (div == 0);
        end
    endtask

    task automatic clear_counters();
        for (int i = 0; i < 8; i++) tick_pat[i] = 0;
        n_done = 0; n_adv = 0; n_idle = 0; n_tick = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; tick = 1'b0;
        model_zero();
        repeat (2) cyc();
        rst = 1'b1;
        div = 0;
        tick = 1'b0;
        clear_counters();
    endtask

    task automatic timeout(string name, int k, int lim);
        if (k >= lim) check(name, k, 0);
    endtask

    task automatic set_default_prog();
        step_time = {16'd3, 16'd5, 16'd2};
        step_out  = {3'b100, 3'b011, 3'b001};
    endtask

    initial begin
        int k;
        set_default_prog();
        clear_counters();
        tick_auto = 1'b0;
        do_reset();
        check("reset_out",  int'(out),       0);
        check("reset_busy", int'(busy),      0);
        check("reset_cnt",  int'(cycle_cnt), 0);

        // Single pass: 2 ticks of 001, 5 of 011, 3 of 100, then idle.
        tick_auto = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        check("start_latency_out", int'(out), 1);
        clear_counters();
        k = 0;
        while (n_done < 1 && k < 400) begin cyc(); k++; end
        timeout("wait_done1", k, 400);
        repeat (3) cyc();
        check("ticks_001", tick_pat[1], 2);
        check("ticks_011", tick_pat[3], 5);
        check("ticks_100", tick_pat[4], 3);
        check("done_once", n_done, 1);
        check("pass_cnt",  int'(cycle_cnt), 1);
        check("pass_out",  int'(out), 0);
        check("pass_busy", int'(busy), 0);

        // Looping: two full sequences without leaving busy.
        do_reset();
        tick_auto = 1'b1;
        loop_en = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        clear_counters();
        k = 0;
        while (n_done < 2 && k < 800) begin cyc(); k++; end
        timeout("wait_done2", k, 800);
        check("loop_done2",  n_done, 2);
        check("loop_cnt",    int'(cycle_cnt), 2);
        check("loop_idle",   n_idle, 0);
        check("loop_adv",    n_adv, 6);
        stop = 1'b1; cyc(); stop = 1'b0;
        loop_en = 1'b0;
        check("loop_stop_busy", int'(busy), 0);

        // Async reset mid step 2 clears everything including cycle_cnt.
        start = 1'b1; cyc(); start = 1'b0;
        k = 0;
        while (step != 2'd2 && k < 400) begin cyc(); k++; end
        timeout("wait_step2", k, 400);
        #2 rst = 1'b0;
        #1;
        check("arst_out",  int'(out), 0);
        check("arst_step", int'(step), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_cnt",  int'(cycle_cnt), 0);
        do_reset();

        // Hold during step 1 after 2 ticks, for 10 ticks, then 3 more ticks.
        tick_auto = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        k = 0;
        while (step != 2'd1 && k < 400) begin cyc(); k++; end
        timeout("wait_step1", k, 400);
        clear_counters();
        k = 0;
        while (tick_pat[3] < 2 && k < 400) begin cyc(); k++; end
        timeout("wait_2ticks", k, 400);
        hold = 1'b1;
        clear_counters();
        k = 0;
        while (n_tick < 10 && k < 400) begin cyc(); k++; end
        timeout("wait_hold", k, 400);
        check("hold_out",  int'(out), 0);
        check("hold_step", int'(step), 1);
        check("hold_busy", int'(busy), 1);
        hold = 1'b0;
        clear_counters();
        k = 0;
        while (step != 2'd2 && k < 400) begin cyc(); k++; end
        timeout("wait_release", k, 400);
        check("release_ticks_011", tick_pat[3], 3);

        // Zero-length step 1 is visible for exactly one clock.
        do_reset();
        tick_auto = 1'b1;
        step_time = {16'd3, 16'd0, 16'd2};
        start = 1'b1; cyc(); start = 1'b0;
        k = 0;
        while (step_adv != 1'b1 && k < 400) begin cyc(); k++; end
        timeout("wait_adv", k, 400);
        check("skip_step1", int'(step), 1);
        cyc();
        check("skip_step2", int'(step), 2);
        check("skip_adv2",  int'(step_adv), 1);
        check("skip_out2",  int'(out), 4);
        set_default_prog();

        // Stop coincident with the completing tick of step 0.
        do_reset();
        tick_auto = 1'b0;
        tick = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1; cyc(); tick = 1'b0;
        cyc();
        tick = 1'b1; stop = 1'b1; cyc(); tick = 1'b0; stop = 1'b0;
        check("stop_busy", int'(busy), 0);
        check("stop_out",  int'(out), 0);
        check("stop_adv",  int'(step_adv), 0);
        check("stop_done", int'(done), 0);
        start = 1'b1; stop = 1'b1; cyc(); cyc();
        check("startstop_busy", int'(busy), 0);
        start = 1'b0; stop = 1'b0;

        // Randomized stimulus with live reprogramming.
        do_reset();
        tick_auto = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                for (int i = 0; i < NS; i++) begin
                    step_time[i*TW +: TW] = TW'($urandom_range(0, 4));
                    step_out[i*OW +: OW]  = OW'($urandom_range(0, 7));
                end
            end
            tick  = ($urandom_range(0, 2) == 0);
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 24) == 0)  hold    = ~hold;
            if ($urandom_range(0, 99) == 0)  loop_en = ~loop_en;
            if ($urandom_range(0, 699) == 0) do_reset();
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
